// File: rtl/simple_st0_out_buffer_pkg.sv
// Shared stage-0/stage-1 stream types: float_24_8 words and the
// {fst, word} entry carried through the output buffer.
package simple_st0_out_buffer_pkg;
    typedef logic [31:0] float_24_8;

    typedef struct packed {
        logic      fst;
        float_24_8 data;
    } out_buf_entry_t;

    // Also used by the stage-0 controller, so both sides agree on frame size.
    localparam int SIMPLE_ST0_FRAME_LEN = 6;
endpackage

// File: rtl/simple_st0_out_buffer_ram.sv
// DEPTH x {fst, float_24_8} storage: synchronous write, asynchronous read.
module simple_st0_out_buffer_ram
    import simple_st0_out_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  out_buf_entry_t wdata,
    input  logic [AW-1:0]  raddr,
    output out_buf_entry_t rdata
);
    out_buf_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/simple_st0_out_buffer.sv
// Registered-output elastic buffer between stage-0 and stage-1 with frame-length
// checking. Define SIMPLE_ST0_OUT_BUFFER_STATS_EN to add max_level/stall_count.
module simple_st0_out_buffer
    import simple_st0_out_buffer_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int FRAME_LEN = SIMPLE_ST0_FRAME_LEN,
    parameter int AFULL     = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   stage_0_data_out,
    input  logic          stage_0_data_out_fst,
    input  logic          stage_0_data_out_vld,
    output logic          stage_0_data_out_rdy,
    output logic [31:0]   stage_1_data,
    output logic          stage_1_data_fst,
    output logic          stage_1_data_vld,
    input  logic          stage_1_data_rdy,
    output logic [AW:0]   level,
    output logic          afull,
    output logic [15:0]   frame_count,
    output logic          len_err
`ifdef SIMPLE_ST0_OUT_BUFFER_STATS_EN
    ,
    output logic [AW:0]   max_level,
    output logic [15:0]   stall_count
`endif
);
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] FL = CW'(FRAME_LEN);

    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    lvl;
    logic           out_vld;
    out_buf_entry_t out_q, in_entry, ram_rdata;
    logic           push, pop, load_out, ram_empty, ram_we;

    assign in_entry             = '{fst: stage_0_data_out_fst, data: stage_0_data_out};
    assign stage_0_data_out_rdy = lvl < (AW+1)'(DEPTH);
    assign push                 = stage_0_data_out_vld && stage_0_data_out_rdy;
    assign pop                  = out_vld && stage_1_data_rdy;
    assign load_out             = !out_vld || pop;
    // The output register is counted in lvl, so the RAM holds lvl - out_vld.
    assign ram_empty            = (lvl - {{AW{1'b0}}, out_vld}) == '0;
    assign ram_we               = push && !(load_out && ram_empty);

    simple_st0_out_buffer_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (in_entry),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            lvl     <= '0;
            out_q   <= '0;
            out_vld <= 1'b0;
        end else begin
            if (ram_we) wr_ptr <= wr_ptr + 1'b1;
            if (load_out) begin
                if (!ram_empty) begin
                    out_q   <= ram_rdata;
                    out_vld <= 1'b1;
                    rd_ptr  <= rd_ptr + 1'b1;
                end else if (push) begin
                    out_q   <= in_entry;
                    out_vld <= 1'b1;
                end else begin
                    out_vld <= 1'b0;
                end
            end
            case ({push, pop})
                2'b10:   lvl <= lvl + 1'b1;
                2'b01:   lvl <= lvl - 1'b1;
                default: lvl <= lvl;
            endcase
        end
    end

    assign stage_1_data     = out_q.data;
    assign stage_1_data_fst = out_q.fst;
    assign stage_1_data_vld = out_vld;
    assign level            = lvl;
    assign afull            = lvl >= (AW+1)'(AFULL);

    // Frame-length check on the accepted input stream.
    logic [CW-1:0] wcnt, wcnt_nxt;
    logic          err_now, frame_done;

    always_comb begin
        wcnt_nxt = wcnt;
        err_now  = 1'b0;
        if (push) begin
            if (stage_0_data_out_fst) begin
                err_now  = (wcnt != FL) && (wcnt != '0);
                wcnt_nxt = CW'(1);
            end else if (wcnt == '0 || wcnt == FL) begin
                err_now = 1'b1;
            end else begin
                wcnt_nxt = wcnt + 1'b1;
            end
        end
    end

    assign frame_done = push && (wcnt_nxt == FL) && (stage_0_data_out_fst || wcnt != FL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt        <= '0;
            frame_count <= '0;
            len_err     <= 1'b0;
        end else begin
            wcnt <= wcnt_nxt;
            if (frame_done) frame_count <= frame_count + 16'd1;
            if (err_now) len_err <= 1'b1;
        end
    end

`ifdef SIMPLE_ST0_OUT_BUFFER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_level   <= '0;
            stall_count <= '0;
        end else begin
            if (lvl > max_level) max_level <= lvl;
            if (stage_0_data_out_vld && !stage_0_data_out_rdy && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_simple_st0_out_buffer.sv
// Scoreboard bench for simple_st0_out_buffer: accepted pushes are queued,
// a monitor pops and compares on every output handshake.
module tb_simple_st0_out_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] stage_0_data_out = '0;
    logic        stage_0_data_out_fst = 1'b0;
    logic        stage_0_data_out_vld = 1'b0;
    logic        stage_0_data_out_rdy;
    logic [31:0] stage_1_data;
    logic        stage_1_data_fst;
    logic        stage_1_data_vld;
    logic        stage_1_data_rdy = 1'b0;
    logic [4:0]  level;
    logic        afull;
    logic [15:0] frame_count;
    logic        len_err;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    bit          acc;

    simple_st0_out_buffer dut (
        .clk(clk), .reset(reset),
        .stage_0_data_out(stage_0_data_out), .stage_0_data_out_fst(stage_0_data_out_fst),
        .stage_0_data_out_vld(stage_0_data_out_vld), .stage_0_data_out_rdy(stage_0_data_out_rdy),
        .stage_1_data(stage_1_data), .stage_1_data_fst(stage_1_data_fst),
        .stage_1_data_vld(stage_1_data_vld), .stage_1_data_rdy(stage_1_data_rdy),
        .level(level), .afull(afull), .frame_count(frame_count), .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; handshakes complete on the next rising edge.
    task automatic drive(input logic [31:0] d, input logic f, input logic ordy, output bit a);
        @(negedge clk);
        stage_0_data_out_vld = 1'b1;
        stage_0_data_out     = d;
        stage_0_data_out_fst = f;
        stage_1_data_rdy     = ordy;
        #1;
        a = stage_0_data_out_rdy;
        if (a) exp_q.push_back({f, d});
    endtask

    task automatic idle();
        @(negedge clk);
        stage_0_data_out_vld = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        stage_0_data_out_vld = 1'b0;
        stage_1_data_rdy     = 1'b0;
        #2;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset && stage_1_data_vld && stage_1_data_rdy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_underflow: got 0x%0h expected no output", stage_1_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", stage_1_data, mon_e[31:0]);
                    check("out_fst", 32'(stage_1_data_fst), 32'(mon_e[32]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        #7;
        check("rst_level", 32'(level), 0);
        check("rst_vld", 32'(stage_1_data_vld), 0);
        check("rst_data", stage_1_data, 0);
        check("rst_fst", 32'(stage_1_data_fst), 0);
        check("rst_frame_count", 32'(frame_count), 0);
        check("rst_len_err", 32'(len_err), 0);
        check("rst_afull", 32'(afull), 0);
        check("rst_in_rdy", 32'(stage_0_data_out_rdy), 1);
        @(negedge clk);
        reset = 1'b1;

        // Single word into empty buffer, latency 1
        drive(32'h3F80_0000, 1'b1, 1'b0, acc);
        check("single_acc", 32'(acc), 1);
        idle();
        check("single_vld", 32'(stage_1_data_vld), 1);
        check("single_data", stage_1_data, 32'h3F80_0000);
        check("single_fst", 32'(stage_1_data_fst), 1);
        check("single_level", 32'(level), 1);
        @(negedge clk);
        stage_1_data_rdy = 1'b1;
        #1;
        idle();
        check("single_drained_vld", 32'(stage_1_data_vld), 0);
        check("single_drained_level", 32'(level), 0);

        // Fill with output stalled, then drain without gaps
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(32'(i), (i % 6) == 0, 1'b0, acc);
            idle();
            check("fill_level", 32'(level), 32'(i + 1));
            check("fill_afull", 32'(afull), 32'((i + 1) >= 12));
        end
        check("full_in_rdy", 32'(stage_0_data_out_rdy), 0);
        drive(32'd16, 1'b0, 1'b0, acc);
        check("full_17th_acc", 32'(acc), 0);
        idle();
        check("full_level", 32'(level), 16);
        @(negedge clk);
        stage_1_data_rdy = 1'b1;
        repeat (16) begin
            #1;
            check("drain_vld", 32'(stage_1_data_vld), 1);
            @(negedge clk);
        end
        #1;
        check("drain_done_vld", 32'(stage_1_data_vld), 0);
        check("drain_q_empty", 32'(exp_q.size()), 0);

        // Steady push+pop at level 5 across pointer wrap
        do_reset();
        for (int i = 0; i < 5; i++) drive(32'(i), (i % 6) == 0, 1'b0, acc);
        idle();
        check("pp_level_init", 32'(level), 5);
        for (int i = 5; i < 25; i++) begin
            drive(32'h100 + 32'(i), (i % 6) == 0, 1'b1, acc);
            check("pp_level", 32'(level), 5);
        end
        repeat (7) idle();
        check("pp_level_end", 32'(level), 0);
        check("pp_q_empty", 32'(exp_q.size()), 0);
        check("pp_len_err", 32'(len_err), 0);

        // Frame counting and length error
        do_reset();
        for (int i = 0; i < 18; i++) drive(32'h200 + 32'(i), (i % 6) == 0, 1'b1, acc);
        idle();
        check("frm_count3", 32'(frame_count), 3);
        check("frm_no_err", 32'(len_err), 0);
        for (int i = 0; i < 5; i++) drive(32'h300 + 32'(i), i == 0, 1'b1, acc);
        check("frm_short_pre", 32'(len_err), 0);
        drive(32'h3FF, 1'b1, 1'b1, acc);
        idle();
        check("frm_short_err", 32'(len_err), 1);
        check("frm_count_hold", 32'(frame_count), 3);
        repeat (3) idle();
        check("frm_err_sticky", 32'(len_err), 1);

        // Missing fst on first post-reset word
        do_reset();
        check("nofst_pre", 32'(len_err), 0);
        drive(32'h7, 1'b0, 1'b1, acc);
        idle();
        check("nofst_err", 32'(len_err), 1);

        // Asynchronous reset mid-frame
        do_reset();
        for (int i = 0; i < 7; i++) drive(32'h400 + 32'(i), (i % 6) == 0, 1'b0, acc);
        idle();
        check("ar_level7", 32'(level), 7);
        check("ar_count1", 32'(frame_count), 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("ar_level0", 32'(level), 0);
        check("ar_vld0", 32'(stage_1_data_vld), 0);
        check("ar_count0", 32'(frame_count), 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) drive(32'h500 + 32'(i), i == 0, 1'b1, acc);
        repeat (3) idle();
        check("ar_new_no_err", 32'(len_err), 0);
        check("ar_new_count", 32'(frame_count), 1);
        check("ar_new_level", 32'(level), 0);
        check("ar_q_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
